// File: rtl/data_ram_pkg.sv
// Shared widths for the RV32I data memory.
package data_ram_pkg;
  localparam int DATA_WIDTH      = 32;
  localparam int BYTE_LANES      = 4;
  localparam int BYTE_WIDTH      = DATA_WIDTH / BYTE_LANES;
  localparam int WORD_ADDR_WIDTH = 30;
endpackage

// File: rtl/data_ram.sv
// ============================================================================
// Module      : data_ram
// Description : Dual-port, byte-write-enabled, read-first synchronous data
//               memory. Port A = CPU load/store path, port B = debug access.
// Revision    : 1.1
// ============================================================================
`default_nettype none
module data_ram
    import data_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter     INIT_FILE  = ""
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BYTE_LANES-1:0]      wea,
    input  logic [WORD_ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0]      dina,
    output logic [DATA_WIDTH-1:0]      douta,
    input  logic [BYTE_LANES-1:0]      web,
    input  logic [WORD_ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0]      dinb,
    output logic [DATA_WIDTH-1:0]      doutb
);

    localparam int C_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [C_DEPTH];
    logic [DATA_WIDTH-1:0] r_douta;
    logic [DATA_WIDTH-1:0] r_doutb;
    logic [ADDR_WIDTH-1:0] w_idx_a;
    logic [ADDR_WIDTH-1:0] w_idx_b;

    assign w_idx_a = addra[ADDR_WIDTH-1:0];
    assign w_idx_b = addrb[ADDR_WIDTH-1:0];

    generate
        if (ADDR_WIDTH < WORD_ADDR_WIDTH) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^{addra[WORD_ADDR_WIDTH-1:ADDR_WIDTH],
                                        addrb[WORD_ADDR_WIDTH-1:ADDR_WIDTH]};
        end
    endgenerate

    initial begin
        for (int k = 0; k < C_DEPTH; k++) begin
            r_mem[k] = '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (web[i]) r_mem[w_idx_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wea[i]) r_mem[w_idx_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_douta <= '0;
        else     r_douta <= r_mem[w_idx_a];
    end

    always_ff @(posedge clk) begin
        if (rst) r_doutb <= '0;
        else     r_doutb <= r_mem[w_idx_b];
    end

    assign douta = r_douta;
    assign doutb = r_doutb;

endmodule
`default_nettype wire

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: directed vector table plus randomized model run.
`default_nettype none
module tb_data_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wea, web;
  logic [29:0] addra, addrb;
  logic [31:0] dina, dinb;
  logic [31:0] douta, doutb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_ram #(.ADDR_WIDTH(12), .INIT_FILE("")) dut (
    .clk   (clk),
    .rst   (rst),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta),
    .web   (web),
    .addrb (addrb),
    .dinb  (dinb),
    .doutb (doutb)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  wea;
    logic [29:0] addra;
    logic [31:0] dina;
    logic [3:0]  web;
    logic [29:0] addrb;
    logic [31:0] dinb;
    logic        chk_a;
    logic [31:0] exp_a;
    logic        chk_b;
    logic [31:0] exp_b;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vec [NVEC];

  function automatic vec_t mk(logic r, logic [3:0] wa, logic [29:0] aa, logic [31:0] da,
                              logic [3:0] wb, logic [29:0] ab, logic [31:0] db,
                              logic ca, logic [31:0] ea, logic cb, logic [31:0] eb);
    vec_t v;
    v.rst = r; v.wea = wa; v.addra = aa; v.dina = da;
    v.web = wb; v.addrb = ab; v.dinb = db;
    v.chk_a = ca; v.exp_a = ea; v.chk_b = cb; v.exp_b = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: only the low 16 words are exercised in the random phase.
  logic [31:0] ref_mem [16];

  initial begin
    logic [31:0] ea, eb;
    logic [3:0]  ia, ib;
    logic [3:0]  rwa, rwb;
    logic [31:0] rda, rdb;
    logic        rr;

    rst = 1'b1; wea = '0; web = '0; addra = '0; addrb = '0; dina = '0; dinb = '0;

    vec[0]  = mk(1, 4'h0, 30'd0,       32'h0,        4'h0, 30'd0,          32'h0,        1, 32'h0,        1, 32'h0);
    vec[1]  = mk(0, 4'hF, 30'd5,       32'hDEADBEEF, 4'h0, 30'd0,          32'h0,        0, 32'h0,        0, 32'h0);
    vec[2]  = mk(0, 4'h0, 30'd5,       32'h0,        4'h0, 30'd5,          32'h0,        1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    vec[3]  = mk(0, 4'b0100, 30'd5,    32'h00AA0000, 4'h0, 30'd0,          32'h0,        1, 32'hDEADBEEF, 0, 32'h0);
    vec[4]  = mk(0, 4'h0, 30'd5,       32'h0,        4'h0, 30'd0,          32'h0,        1, 32'hDEAABEEF, 0, 32'h0);
    vec[5]  = mk(0, 4'b0001, 30'd5,    32'h00000011, 4'h0, 30'd0,          32'h0,        1, 32'hDEAABEEF, 0, 32'h0);
    vec[6]  = mk(0, 4'h0, 30'd5,       32'h0,        4'h0, 30'd0,          32'h0,        1, 32'hDEAABE11, 0, 32'h0);
    vec[7]  = mk(0, 4'b0010, 30'd5,    32'h00002200, 4'h0, 30'd0,          32'h0,        1, 32'hDEAABE11, 0, 32'h0);
    vec[8]  = mk(0, 4'h0, 30'd5,       32'h0,        4'h0, 30'd0,          32'h0,        1, 32'hDEAA2211, 0, 32'h0);
    vec[9]  = mk(0, 4'b1000, 30'd5,    32'h33000000, 4'h0, 30'd0,          32'h0,        1, 32'hDEAA2211, 0, 32'h0);
    vec[10] = mk(0, 4'h0, 30'd5,       32'h0,        4'h0, 30'd5,          32'h0,        1, 32'h33AA2211, 1, 32'h33AA2211);
    vec[11] = mk(0, 4'hF, 30'd7,       32'h11111111, 4'h0, 30'd0,          32'h0,        0, 32'h0,        0, 32'h0);
    vec[12] = mk(0, 4'hF, 30'd7,       32'h22222222, 4'h0, 30'd0,          32'h0,        1, 32'h11111111, 0, 32'h0);
    vec[13] = mk(0, 4'h0, 30'd7,       32'h0,        4'h0, 30'd0,          32'h0,        1, 32'h22222222, 0, 32'h0);
    vec[14] = mk(0, 4'hF, 30'd3,       32'hA5A5A5A5, 4'h0, 30'd3,          32'h0,        0, 32'h0,        0, 32'h0);
    vec[15] = mk(0, 4'h0, 30'd3,       32'h0,        4'h0, 30'd3,          32'h0,        1, 32'hA5A5A5A5, 1, 32'hA5A5A5A5);
    vec[16] = mk(0, 4'hF, 30'd3,       32'h01010101, 4'hF, 30'd3,          32'h02020202, 1, 32'hA5A5A5A5, 1, 32'hA5A5A5A5);
    vec[17] = mk(0, 4'h0, 30'd3,       32'h0,        4'h0, 30'd3,          32'h0,        1, 32'h01010101, 1, 32'h01010101);
    vec[18] = mk(0, 4'b0011, 30'd3,    32'h0000AAAA, 4'hF, 30'd3,          32'hBBBBBBBB, 1, 32'h01010101, 1, 32'h01010101);
    vec[19] = mk(0, 4'h0, 30'd3,       32'h0,        4'h0, 30'd3,          32'h0,        1, 32'hBBBBAAAA, 1, 32'hBBBBAAAA);
    vec[20] = mk(1, 4'hF, 30'd9,       32'h12345678, 4'h0, 30'd3,          32'h0,        1, 32'h0,        1, 32'h0);
    vec[21] = mk(0, 4'h0, 30'd9,       32'h0,        4'h0, 30'd3,          32'h0,        1, 32'h12345678, 1, 32'hBBBBAAAA);
    vec[22] = mk(0, 4'hF, 30'h1000,    32'hCAFEF00D, 4'h0, 30'd9,          32'h0,        0, 32'h0,        1, 32'h12345678);
    vec[23] = mk(0, 4'h0, 30'd0,       32'h0,        4'h0, 30'h3FFFF000,   32'h0,        1, 32'hCAFEF00D, 1, 32'hCAFEF00D);

    for (int i = 0; i < NVEC; i++) begin
      rst = vec[i].rst; wea = vec[i].wea; addra = vec[i].addra; dina = vec[i].dina;
      web = vec[i].web; addrb = vec[i].addrb; dinb = vec[i].dinb;
      @(posedge clk); #1;
      if (vec[i].chk_a) check($sformatf("vec%0d_douta", i), douta, vec[i].exp_a);
      if (vec[i].chk_b) check($sformatf("vec%0d_doutb", i), doutb, vec[i].exp_b);
    end

    // Seed the model's 16 words through port A.
    rst = 1'b0; web = '0;
    for (int w = 0; w < 16; w++) begin
      wea = 4'hF; addra = 30'(w); dina = $urandom;
      ref_mem[w] = dina;
      @(posedge clk); #1;
    end

    // Random traffic; upper address bits are random to exercise aliasing.
    for (int n = 0; n < 400; n++) begin
      ia = 4'($urandom_range(0, 15));
      ib = 4'($urandom_range(0, 15));
      rwa = 4'($urandom); rwb = 4'($urandom);
      rda = $urandom;     rdb = $urandom;
      rr  = ($urandom_range(0, 15) == 0);

      ea = rr ? 32'h0 : ref_mem[ia];
      eb = rr ? 32'h0 : ref_mem[ib];
      for (int l = 0; l < 4; l++) begin
        if (rwb[l]) ref_mem[ib][8*l +: 8] = rdb[8*l +: 8];
        if (rwa[l]) ref_mem[ia][8*l +: 8] = rda[8*l +: 8];
      end

      rst = rr; wea = rwa; web = rwb; dina = rda; dinb = rdb;
      addra = {18'($urandom), 8'h00, ia};
      addrb = {18'($urandom), 8'h00, ib};
      @(posedge clk); #1;
      check($sformatf("rand%0d_douta", n), douta, ea);
      check($sformatf("rand%0d_doutb", n), doutb, eb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
